conv_window_feeder: RTL and testbench

Streams an IMG_H×IMG_W 8-bit feature map in raster order, keeps the last KENNEL_SIZE rows in a ring line buffer, and presents every valid 5×5 window to the convolution MAC array as a 200-bit `imaps` word. It drives `imVld` and holds it until the MAC array returns `covResVld`. It captures each `covSum` into an ordered result stream with a last-result flag. It sits between the pixel source and `conv_mul_add_array` and implements the initiator side of that array's valid-hold protocol.

---
 rtl/lenet_pkg.sv | 18 +
 rtl/conv_line_buffer.sv | 70 +++++++
 rtl/conv_window_feeder.sv | 168 ++++++++++++++++
 tb/tb_conv_window_feeder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet convolution datapath.
//   DATA_SIZE      - pixel width in bits
//   KENNEL_SIZE    - convolution kernel edge
//   halfword_width - width of MAC results
//   feederState_t  - state encoding of conv_window_feeder
package lenet_pkg;
    localparam int DATA_SIZE      = 8;
    localparam int KENNEL_SIZE    = 5;
    localparam int halfword_width = 16;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } feederState_t;
endpackage

// File: rtl/conv_line_buffer.sv
// Ring of KENNEL_SIZE feature-map rows plus the window extract mux.
//   clk, rst  - clock, async active-high reset (clears the ring pointer)
//   wrEn      - write wrData at row (ptr + wrRowOff) mod KENNEL_SIZE, column wrCol
//   ptrAdv    - rotate the ring by one row (oldest row becomes newest)
//   ptrClr    - return the ring pointer to physical row 0
//   col       - leftmost column of the requested window
//   window    - packed KENNEL_SIZE x KENNEL_SIZE window, element (0,0) in the MSBs
module conv_line_buffer #(
    parameter int IMG_W       = 32,
    parameter int KENNEL_SIZE = lenet_pkg::KENNEL_SIZE,
    parameter int DATA_SIZE   = lenet_pkg::DATA_SIZE
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           wrEn,
    input  logic [$clog2(KENNEL_SIZE)-1:0]                 wrRowOff,
    input  logic [$clog2(IMG_W)-1:0]                       wrCol,
    input  logic [DATA_SIZE-1:0]                           wrData,
    input  logic                                           ptrAdv,
    input  logic                                           ptrClr,
    input  logic [$clog2(IMG_W)-1:0]                       col,
    output logic [KENNEL_SIZE*KENNEL_SIZE*DATA_SIZE-1:0]   window
);
    import lenet_pkg::*;

    localparam int RW = $clog2(KENNEL_SIZE);
    localparam int CW = $clog2(IMG_W);
    localparam int NE = KENNEL_SIZE * KENNEL_SIZE;

    logic [DATA_SIZE-1:0] mem [KENNEL_SIZE][IMG_W];
    logic [RW-1:0]        ptr;
    logic [RW-1:0]        wrRow;

    // (base + off) mod KENNEL_SIZE, with off < KENNEL_SIZE
    function automatic logic [RW-1:0] ringRow(input logic [RW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= KENNEL_SIZE) s = s - KENNEL_SIZE;
        return s[RW-1:0];
    endfunction

    assign wrRow = ringRow(ptr, int'(wrRowOff));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (ptrClr) begin
            ptr <= '0;
        end else if (ptrAdv) begin
            ptr <= ringRow(ptr, 1);
        end
    end

    // Pixel storage carries no reset: every row is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrRow][wrCol] <= wrData;
        end
    end

    always_comb begin
        window = '0;
        for (int r = 0; r < KENNEL_SIZE; r++) begin
            for (int c = 0; c < KENNEL_SIZE; c++) begin
                window[(NE-1-(r*KENNEL_SIZE+c))*DATA_SIZE +: DATA_SIZE] =
                    mem[ringRow(ptr, r)][CW'(int'(col) + c)];
            end
        end
    end
endmodule

// File: rtl/conv_window_feeder.sv
// Streams a raster-order feature map into a ring line buffer and presents each
// valid KENNEL_SIZE x KENNEL_SIZE window to the MAC array, holding imVld until
// the array answers, then forwards each result in raster order.
//   clk, rst           - clock, async active-high reset
//   pixIn/pixVld/pixRdy - pixel stream in (transfer = pixVld & pixRdy)
//   wVld               - MAC weights valid; dropping it mid-window aborts the window
//   imaps/imVld        - window to MAC array, held stable while imVld
//   covSum/covResVld   - MAC array result
//   resOut/resVld      - captured result, one-cycle pulse
//   resLast            - marks the final result of a frame
//   frameDone          - one-cycle pulse after the final result
//
// state    | meaning
// ST_LOAD  | accept pixels: five rows for band 0, one row per later band
// ST_ISSUE | wait for wVld, then latch the window and raise imVld
// ST_WAIT  | hold imVld until covResVld (result) or wVld drop (abort)
// ST_GAP   | imVld low; pick next column/band or retry the aborted column
// ST_DONE  | frame complete, rewind band count and ring pointer
module conv_window_feeder #(
    parameter int IMG_W       = 32,
    parameter int IMG_H       = 32,
    parameter int KENNEL_SIZE = lenet_pkg::KENNEL_SIZE,
    parameter int DATA_SIZE   = lenet_pkg::DATA_SIZE
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [DATA_SIZE-1:0]                         pixIn,
    input  logic                                         pixVld,
    output logic                                         pixRdy,
    input  logic                                         wVld,
    output logic [KENNEL_SIZE*KENNEL_SIZE*DATA_SIZE-1:0] imaps,
    output logic                                         imVld,
    input  logic [lenet_pkg::halfword_width-1:0]         covSum,
    input  logic                                         covResVld,
    output logic [lenet_pkg::halfword_width-1:0]         resOut,
    output logic                                         resVld,
    output logic                                         resLast,
    output logic                                         frameDone
);
    import lenet_pkg::*;

    localparam int CW        = $clog2(IMG_W);
    localparam int RW        = $clog2(KENNEL_SIZE);
    localparam int BW        = $clog2(IMG_H);
    localparam int LAST_COL  = IMG_W - KENNEL_SIZE;
    localparam int LAST_BAND = IMG_H - KENNEL_SIZE;

    feederState_t                                 state;
    logic [CW-1:0]                                col;
    logic [BW-1:0]                                band;
    logic [CW-1:0]                                pixCnt;
    logic [RW-1:0]                                loadRow;
    logic                                         retry;
    logic                                         firstBand;
    logic                                         lastPix;
    logic                                         wrEn;
    logic                                         ptrAdv;
    logic                                         ptrClr;
    logic [RW-1:0]                                wrRowOff;
    logic [KENNEL_SIZE*KENNEL_SIZE*DATA_SIZE-1:0] window;

    assign firstBand = (band == '0);
    assign lastPix   = pixVld && (pixCnt == CW'(IMG_W - 1))
                       && (!firstBand || loadRow == RW'(KENNEL_SIZE - 1));
    assign pixRdy    = (state == ST_LOAD) && !rst;
    assign wrEn      = (state == ST_LOAD) && pixVld;
    // Band 0 fills the ring top to bottom; later bands overwrite the oldest row.
    assign wrRowOff  = firstBand ? loadRow : '0;
    assign ptrAdv    = (state == ST_LOAD) && lastPix && !firstBand;
    assign ptrClr    = (state == ST_DONE);

    conv_line_buffer #(
        .IMG_W       (IMG_W),
        .KENNEL_SIZE (KENNEL_SIZE),
        .DATA_SIZE   (DATA_SIZE)
    ) u_lineBuf (
        .clk      (clk),
        .rst      (rst),
        .wrEn     (wrEn),
        .wrRowOff (wrRowOff),
        .wrCol    (pixCnt),
        .wrData   (pixIn),
        .ptrAdv   (ptrAdv),
        .ptrClr   (ptrClr),
        .col      (col),
        .window   (window)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_LOAD;
            col       <= '0;
            band      <= '0;
            pixCnt    <= '0;
            loadRow   <= '0;
            retry     <= 1'b0;
            imaps     <= '0;
            imVld     <= 1'b0;
            resOut    <= '0;
            resVld    <= 1'b0;
            resLast   <= 1'b0;
            frameDone <= 1'b0;
        end else begin
            resVld    <= 1'b0;
            resLast   <= 1'b0;
            frameDone <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (lastPix) begin
                        pixCnt  <= '0;
                        loadRow <= '0;
                        col     <= '0;
                        state   <= ST_ISSUE;
                    end else if (pixVld) begin
                        if (pixCnt == CW'(IMG_W - 1)) begin
                            pixCnt  <= '0;
                            loadRow <= loadRow + 1'b1;
                        end else begin
                            pixCnt <= pixCnt + 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (wVld) begin
                        imaps <= window;
                        imVld <= 1'b1;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A result wins over a simultaneous weight drop.
                    if (covResVld) begin
                        resOut  <= covSum;
                        resVld  <= 1'b1;
                        resLast <= (band == BW'(LAST_BAND)) && (col == CW'(LAST_COL));
                        imVld   <= 1'b0;
                        retry   <= 1'b0;
                        state   <= ST_GAP;
                    end else if (!wVld) begin
                        imVld <= 1'b0;
                        retry <= 1'b1;
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // One GAP cycle plus the ISSUE cycle keep imVld low for two cycles.
                    if (retry) begin
                        state <= ST_ISSUE;
                    end else if (col != CW'(LAST_COL)) begin
                        col   <= col + 1'b1;
                        state <= ST_ISSUE;
                    end else if (band != BW'(LAST_BAND)) begin
                        band  <= band + 1'b1;
                        state <= ST_LOAD;
                    end else begin
                        frameDone <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    band  <= '0;
                    state <= ST_LOAD;
                end
                default: state <= ST_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_window_feeder.sv
module tb_conv_window_feeder;
    localparam int IMG_W = 32;
    localparam int IMG_H = 32;
    localparam int K     = 5;
    localparam int NC    = IMG_W - K + 1;
    localparam int NR    = IMG_H - K + 1;
    localparam int TOTAL = NC * NR;

    logic         clk;
    logic         rst;
    logic [7:0]   pixIn;
    logic         pixVld;
    logic         pixRdy;
    logic         wVld;
    logic [199:0] imaps;
    logic         imVld;
    logic [15:0]  covSum;
    logic         covResVld;
    logic [15:0]  resOut;
    logic         resVld;
    logic         resLast;
    logic         frameDone;

    conv_window_feeder #(.IMG_W(IMG_W), .IMG_H(IMG_H), .KENNEL_SIZE(K), .DATA_SIZE(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .pixIn     (pixIn),
        .pixVld    (pixVld),
        .pixRdy    (pixRdy),
        .wVld      (wVld),
        .imaps     (imaps),
        .imVld     (imVld),
        .covSum    (covSum),
        .covResVld (covResVld),
        .resOut    (resOut),
        .resVld    (resVld),
        .resLast   (resLast),
        .frameDone (frameDone)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;

    // model / tracking state, owned by the per-cycle process
    int cyc = 0;
    int idx = 0;
    int resIdx = 0;
    int framesDone = 0;
    int riseCyc = 0;
    int fallCyc = 0;
    int doneCyc = -1;
    int macCnt = 0;
    int abortsSeen = 0;
    bit prevImVld = 0;
    bit retry = 0;
    bit abortInjected = 0;
    // stimulus modes, set by the main sequence
    bit gapMode = 0;
    bit abortArm = 0;

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pixVal(input int row, input int c);
        return (row * IMG_W + c) & 255;
    endfunction

    function automatic logic [199:0] expWin(input int k);
        logic [199:0] w;
        int b;
        int c0;
        b = k / NC;
        c0 = k % NC;
        w = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                w[199 - 8*(K*r + c) -: 8] = 8'(pixVal(b + r, c0 + c));
        return w;
    endfunction

    function automatic int expSum(input int k);
        int s;
        s = 0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                s += pixVal(k / NC + r, k % NC + c);
        return s & 16'hFFFF;
    endfunction

    function automatic logic [15:0] macSum(input logic [199:0] w);
        int s;
        s = 0;
        for (int i = 0; i < 25; i++) s += int'(w[8*i +: 8]);
        return 16'(s);
    endfunction

    // Per-cycle compare process plus the MAC array and pixel source models.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                idx = 0; resIdx = 0; doneCyc = -1; macCnt = 0;
                prevImVld = 0; retry = 0; abortInjected = 0;
                covResVld = 0; covSum = 0; pixVld = 0; pixIn = 0; wVld = 1;
            end else begin
                if (imVld) begin
                    chk("imaps", imaps, expWin(resIdx));
                    chk("pixRdy_busy", 200'(pixRdy), 200'(0));
                end
                if (imVld && !prevImVld) begin
                    if (resIdx == 0 && !retry) begin
                        chk("win0_top", 200'(imaps[199:192]), 200'(8'h00));
                        chk("win0_low", 200'(imaps[7:0]), 200'(8'h84));
                    end
                    if (resIdx % NC != 0 || retry)
                        chk("gap_len", 200'(cyc - fallCyc), 200'(2));
                    if (resIdx % NC != 0 && !retry)
                        chk("period", 200'(cyc - riseCyc), 200'(10));
                    riseCyc = cyc;
                end
                if (!imVld && prevImVld) begin
                    fallCyc = cyc;
                    if (!resVld) begin
                        chk("abort_expected", 200'(abortInjected && retry == 0), 200'(1));
                        chk("abort_fall", 200'(cyc - riseCyc), 200'(5));
                        abortsSeen++;
                        retry = 1;
                    end else begin
                        retry = 0;
                    end
                end
                if (resVld) begin
                    chk("resOut", 200'(resOut), 200'(expSum(resIdx)));
                    chk("resLast", 200'(resLast), 200'(resIdx == TOTAL - 1));
                    chk("res_latency", 200'(cyc - riseCyc), 200'(8));
                    chk("pixRdy_gap", 200'(pixRdy), 200'(0));
                    if (resIdx == 0) chk("res0_lit", 200'(resOut), 200'(1650));
                    if (resIdx == TOTAL - 1) begin
                        chk("resLast_lit", 200'(resOut), 200'(4725));
                        doneCyc = cyc + 1;
                    end
                    resIdx++;
                end
                if (frameDone || cyc == doneCyc) begin
                    chk("frameDone", 200'(frameDone), 200'(cyc == doneCyc));
                    chk("frame_results", 200'(resIdx), 200'(TOTAL));
                    chk("frame_pixels", 200'(idx), 200'(IMG_W * IMG_H));
                    framesDone++;
                    resIdx = 0; idx = 0; doneCyc = -1;
                end
                prevImVld = imVld;

                macCnt = imVld ? macCnt + 1 : 0;
                covResVld = (macCnt == 8);
                covSum = covResVld ? macSum(imaps) : 16'h0;

                wVld = 1;
                if (abortArm && !abortInjected && !retry && resIdx == 3 && imVld && cyc - riseCyc == 4) begin
                    wVld = 0;
                    abortInjected = 1;
                end

                pixVld = gapMode ? 1'($urandom_range(0, 1)) : 1'b1;
                pixIn = 8'(idx & 255);
                if (pixVld && pixRdy) idx++;
            end
        end
    end

    task automatic waitFrames(input int n, output bit ok);
        int budget;
        budget = 0;
        ok = 1;
        while (framesDone < n) begin
            @(negedge clk); #1;
            budget++;
            if (budget > 30000) begin
                ok = 0;
                return;
            end
        end
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, "_imVld"}, 200'(imVld), 200'(0));
        chk({tag, "_resVld"}, 200'(resVld), 200'(0));
        chk({tag, "_resLast"}, 200'(resLast), 200'(0));
        chk({tag, "_frameDone"}, 200'(frameDone), 200'(0));
        chk({tag, "_pixRdy"}, 200'(pixRdy), 200'(0));
        chk({tag, "_imaps"}, imaps, 200'(0));
        chk({tag, "_resOut"}, 200'(resOut), 200'(0));
    endtask

    task automatic finishRun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    initial begin
        bit ok;
        int budget;
        rst = 1; pixVld = 0; pixIn = 0; wVld = 1; covResVld = 0; covSum = 0;
        repeat (3) @(negedge clk);
        #1 checkAllZero("reset");
        rst = 0;
        #1 chk("pixRdy_after_rst", 200'(pixRdy), 200'(1));

        // frame 1: continuous pixels
        waitFrames(1, ok);
        if (!ok) begin chk("timeout_frame1", 200'(framesDone), 200'(1)); finishRun(); end

        // frame 2 back-to-back: random pixel gaps and one aborted window
        gapMode = 1; abortArm = 1;
        waitFrames(2, ok);
        if (!ok) begin chk("timeout_frame2", 200'(framesDone), 200'(2)); finishRun(); end
        chk("aborts_seen", 200'(abortsSeen), 200'(1));
        gapMode = 0; abortArm = 0;

        // frame 3: reset in the middle of a WAIT in band 10
        budget = 0;
        while (!(resIdx == 10 * NC + 5 && imVld && cyc - riseCyc == 3) && budget < 30000) begin
            @(negedge clk); #1;
            budget++;
        end
        if (budget >= 30000) begin chk("timeout_band10", 200'(resIdx), 200'(10 * NC + 5)); finishRun(); end
        rst = 1;
        #1 checkAllZero("midwait_rst");
        repeat (3) @(negedge clk);
        #1 rst = 0;

        // frame 4: fresh frame after reset
        waitFrames(3, ok);
        if (!ok) begin chk("timeout_frame4", 200'(framesDone), 200'(3)); finishRun(); end
        finishRun();
    end
endmodule
